spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI responder: the target end of the SPI initiator used for the ADC link. Lets the fabric answer an SPI master, and lets a second FPGA or a loopback bench stand in for the ADC.
- Mode 0, MSB first, 16-bit words. Samples MOSI on SCLK rising edges and drives MISO after SCLK falling edges.
- All SPI pins are oversampled in the clk domain; the block has no SCLK-clocked logic.
- The fabric side is a one-word transmit buffer with a ready/write handshake and a received-word valid pulse.

Parameters:
- WIDTH, 16, bits per word.
- SYNC_STAGES, 2, synchroniser flops on SCLK, SS and MOSI (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCLK frequency.
- resn  input  1  asynchronous active-low reset.
- SCLK  input  1  SPI clock from the master; idles low.
- SS  input  1  slave select, active low.
- MOSI  input  1  master-out data.
- MISO  output  1  slave-out data; driven 0 while deselected.
- txData  input  WIDTH  word to send in a later frame slot.
- txWrite  input  1  loads txData into the buffer when txReady=1.
- txReady  output  1  transmit buffer empty.
- rxData  output  WIDTH  last complete received word; held until the next word completes.
- rxValid  output  1  one-clk pulse when rxData updates.
- busy  output  1  synchronised SS is low.
- abort  output  1  one-clk pulse when SS rises mid-word.
- txUnderrun  output  1  one-clk pulse when a word slot starts with the buffer empty.

Behaviour:
- Reset (asynchronous, resn=0):
  - Outputs: MISO=0, txReady=1, rxData=0, rxValid=0, busy=0, abort=0, txUnderrun=0.
  - Internal: buffer empty, bit counter=0, shift registers=0, synchronisers set to the idle levels (SCLK=0, SS=1).
- Synchronisation:
  - Each pin passes through SYNC_STAGES flops, then one history flop for edge detection.
  - Edge events (SCLK rise, SCLK fall, SS fall, SS rise) are single-cycle and occur SYNC_STAGES+1 clk cycles after the pin change.
  - SCLK edges are ignored while synchronised SS=1.
- States:
  - IDLE: SS high, MISO=0. On SS fall: go to ACTIVE, bit counter=0, do a slot load, MISO = shift[WIDTH-1] in the same cycle.
  - ACTIVE, SCLK rise: rx shift <= {rx shift[WIDTH-2:0], MOSI}; counter+1.
    - When the counter reaches WIDTH: rxData <= completed word, rxValid=1 next cycle, counter <= 0, set the reload flag.
  - ACTIVE, SCLK fall with reload flag clear and counter!=0: tx shift shifts left, MISO = new MSB.
  - ACTIVE, SCLK fall with reload flag set: slot load, MISO = new MSB, clear the flag. Back-to-back words within one SS-low period are supported without gaps.
  - ACTIVE, SS rise: go to IDLE, MISO=0, counter=0.
    - If the counter was not 0, pulse abort and discard the partial word; rxData is unchanged.
    - A loaded but unsent tx word is lost; the buffer is not refilled from it.
- Slot load:
  - Buffer full: shift <= buffer, buffer emptied, txReady=1 next cycle.
  - Buffer empty: shift <= 0 and txUnderrun pulses, except for the bypass case below.
- Transmit buffer:
  - txWrite with txReady=1: buffer <= txData, txReady=0 next cycle.
  - txWrite with txReady=0: ignored, buffer unchanged.
  - Bypass: txWrite in the same cycle as a slot load with an empty buffer sends txData directly to the shift register. No underrun is signalled and the buffer stays empty.
  - Writes are accepted in any state.
- Simultaneous events:
  - SS fall and SS rise cannot coincide.
  - SS rise in the same cycle as an SCLK edge: SS rise wins and the edge is dropped.
  - rxValid and abort never pulse in the same cycle.
- busy mirrors synchronised SS inverted, registered.

Test Plan:
- Load txData=16'hA55A, then run one 16-bit frame with MOSI=16'h1234 at SCLK = clk/68 -> MISO bits read by the master = A55A, rxData=16'h1234, one rxValid pulse, txReady back to 1 after the SS fall, no abort or underrun.
- Two back-to-back words under one SS-low (MOSI 16'hBEEF then 16'h0001), buffer refilled between words with 16'h0F0F -> rxValid pulses twice with BEEF then 0001; second MISO word = 0F0F.
- Frame with the buffer empty -> MISO all zeros, txUnderrun pulses once at the SS fall, and rxData still captures MOSI.
- SS raised after 7 rising SCLK edges -> abort pulses once, rxData keeps its previous value, MISO=0, and the next full frame decodes correctly.
- txWrite of 16'h1111 while buffer full with 16'h2222 -> txReady stays 0 and the next frame sends 2222. txWrite of 16'h3333 in the SS-fall slot-load cycle with an empty buffer -> frame sends 3333 with no underrun.
- resn pulsed low mid-frame (after 9 bits) -> all outputs immediately at reset values, and the next frame after release decodes correctly.

Source files
------------

// File: rtl/spi_slave_if.sv
// Bus bundle for spi_slave: SPI pins plus the fabric-side tx buffer and rx word handshake.
interface spi_slave_if #(
   parameter int WIDTH = 16
);
   logic             SCLK;
   logic             SS;
   logic             MOSI;
   logic             MISO;
   logic [WIDTH-1:0] txData;
   logic             txWrite;
   logic             txReady;
   logic [WIDTH-1:0] rxData;
   logic             rxValid;
   logic             busy;
   logic             abort;
   logic             txUnderrun;

   modport slave (
      input  SCLK, SS, MOSI, txData, txWrite,
      output MISO, txReady, rxData, rxValid, busy, abort, txUnderrun
   );

   modport master (
      output SCLK, SS, MOSI, txData, txWrite,
      input  MISO, txReady, rxData, rxValid, busy, abort, txUnderrun
   );
endinterface

// File: rtl/spi_slave.sv
// Mode 0 SPI responder, MSB first, with every SPI pin oversampled in the clk domain.
// One-word transmit buffer on the fabric side; the received word is held until the next one completes.
//
// state     | meaning
// ST_IDLE   | SS high, MISO held at 0
// ST_ACTIVE | SS low, shifting words on synchronised SCLK edges
module spi_slave #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        resn,
   spi_slave_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
   logic                   sclk_hist_q, ss_hist_q;
   logic                   sclk_s, ss_s, mosi_s;
   logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;

   state_t           state_q,    state_d;
   logic [CW-1:0]    cnt_q,      cnt_d;
   logic             reload_q,   reload_d;
   logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [WIDTH-1:0] buf_q,      buf_d;
   logic             buf_full_q, buf_full_d;
   logic [WIDTH-1:0] rx_data_q,  rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             abort_q,    abort_d;
   logic             underrun_q, underrun_d;
   logic             busy_q,     busy_d;
   logic             slot_load;
   logic [WIDTH-1:0] rx_word;

   // Synchronisers reset to the idle pin levels so release from reset never fakes an edge.
   always_ff @(posedge clk or negedge resn) begin
      if (!resn) begin
         sclk_sync_q <= '0;
         ss_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_hist_q <= 1'b0;
         ss_hist_q   <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.SCLK};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0],   bus.SS};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
         sclk_hist_q <= sclk_s;
         ss_hist_q   <= ss_s;
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise =  sclk_s & ~sclk_hist_q;
   assign sclk_fall = ~sclk_s &  sclk_hist_q;
   assign ss_fall   = ~ss_s   &  ss_hist_q;
   assign ss_rise   =  ss_s   & ~ss_hist_q;

   always_ff @(posedge clk or negedge resn) begin
      if (!resn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         reload_q   <= 1'b0;
         rx_shift_q <= '0;
         tx_shift_q <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         abort_q    <= 1'b0;
         underrun_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         reload_q   <= reload_d;
         rx_shift_q <= rx_shift_d;
         tx_shift_q <= tx_shift_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         abort_q    <= abort_d;
         underrun_q <= underrun_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      reload_d   = reload_q;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      abort_d    = 1'b0;
      underrun_d = 1'b0;
      busy_d     = ~ss_s;
      slot_load  = 1'b0;
      rx_word    = {rx_shift_q[WIDTH-2:0], mosi_s};

      if (bus.txWrite && !buf_full_q) begin
         buf_d      = bus.txData;
         buf_full_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (ss_fall) begin
               state_d   = ST_ACTIVE;
               cnt_d     = '0;
               reload_d  = 1'b0;
               slot_load = 1'b1;
            end
         end
         ST_ACTIVE: begin
            // SS rise takes priority over any SCLK edge seen in the same cycle.
            if (ss_rise) begin
               state_d  = ST_IDLE;
               cnt_d    = '0;
               reload_d = 1'b0;
               abort_d  = (cnt_q != '0);
            end else if (sclk_rise) begin
               rx_shift_d = rx_word;
               if (cnt_q == CW'(WIDTH-1)) begin
                  rx_data_d  = rx_word;
                  rx_valid_d = 1'b1;
                  cnt_d      = '0;
                  reload_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (sclk_fall) begin
               if (reload_q) begin
                  slot_load = 1'b1;
                  reload_d  = 1'b0;
               end else if (cnt_q != '0) begin
                  tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // An empty buffer plus a same-cycle write goes straight to the shifter.
      if (slot_load) begin
         if (buf_full_q) begin
            tx_shift_d = buf_q;
            buf_full_d = 1'b0;
         end else if (bus.txWrite) begin
            tx_shift_d = bus.txData;
            buf_full_d = 1'b0;
         end else begin
            tx_shift_d = '0;
            underrun_d = 1'b1;
         end
      end
   end

   assign bus.MISO       = (state_q == ST_ACTIVE) & tx_shift_q[WIDTH-1];
   assign bus.txReady    = ~buf_full_q;
   assign bus.rxData     = rx_data_q;
   assign bus.rxValid    = rx_valid_q;
   assign bus.busy       = busy_q;
   assign bus.abort      = abort_q;
   assign bus.txUnderrun = underrun_q;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: acts as a mode 0 SPI master at SCLK = clk/68 and checks against a word-level model.
module tb_spi_slave;
   localparam int W    = 16;
   localparam int HALF = 34;

   logic clk  = 1'b0;
   logic resn = 1'b0;

   spi_slave_if #(.WIDTH(W)) bus ();

   spi_slave #(.WIDTH(W), .SYNC_STAGES(2)) dut (
      .clk  (clk),
      .resn (resn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Word-level model state
   logic          m_buf_full = 1'b0;
   logic [15:0]   m_buf      = '0;
   logic [15:0]   exp_rx[$];
   int            exp_abort = 0, exp_under = 0, exp_rxv = 0;
   int            obs_abort = 0, obs_under = 0, obs_rxv = 0;
   logic [15:0]   m_last_rx = '0;
   int            ss_stable = 0;
   logic          ss_prev   = 1'b1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tx_write(input logic [15:0] d);
      @(negedge clk);
      bus.txData  = d;
      bus.txWrite = 1'b1;
      if (!m_buf_full) begin
         m_buf      = d;
         m_buf_full = 1'b1;
      end
      @(negedge clk);
      bus.txWrite = 1'b0;
      chk("txReady_after_write", bus.txReady, !m_buf_full);
   endtask

   task automatic model_slot(output logic [15:0] w);
      if (m_buf_full) begin
         w          = m_buf;
         m_buf_full = 1'b0;
      end else begin
         w = '0;
         exp_under++;
      end
   endtask

   task automatic ss_fall(output logic [15:0] w);
      @(negedge clk);
      bus.SS = 1'b0;
      model_slot(w);
   endtask

   // txWrite lands on the clk edge where the synchronised SS fall is acted upon.
   task automatic ss_fall_bypass(input logic [15:0] d, output logic [15:0] w);
      @(negedge clk);
      bus.SS = 1'b0;
      repeat (2) @(negedge clk);
      bus.txData  = d;
      bus.txWrite = 1'b1;
      @(negedge clk);
      bus.txWrite = 1'b0;
      if (m_buf_full) begin
         w          = m_buf;
         m_buf_full = 1'b0;
      end else begin
         w = d;
      end
   endtask

   // Ends a frame by raising SS together with the final SCLK fall.
   task automatic spi_bits(input logic [15:0] mosi, input int nbits, input bit last,
                           output logic [15:0] miso);
      miso = '0;
      for (int i = 0; i < nbits; i++) begin
         bus.MOSI = mosi[15-i];
         if (i == 15) begin
            exp_rx.push_back(mosi);
            exp_rxv++;
         end
         tick(HALF);
         bus.SCLK     = 1'b1;
         miso[15-i]   = bus.MISO;
         tick(HALF);
         bus.SCLK = 1'b0;
         if (last && i == nbits - 1) bus.SS = 1'b1;
      end
      bus.MOSI = 1'b0;
      if (last && nbits != 16) exp_abort++;
      if (last) tick(2*HALF);
   endtask

   task automatic chk_events(input string tag);
      chk({tag, "_abort_count"},    obs_abort,     exp_abort);
      chk({tag, "_underrun_count"}, obs_under,     exp_under);
      chk({tag, "_rxValid_count"},  obs_rxv,       exp_rxv);
      chk({tag, "_rx_pending"},     exp_rx.size(), 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_MISO"},       bus.MISO,       0);
      chk({tag, "_txReady"},    bus.txReady,    1);
      chk({tag, "_rxData"},     bus.rxData,     0);
      chk({tag, "_rxValid"},    bus.rxValid,    0);
      chk({tag, "_busy"},       bus.busy,       0);
      chk({tag, "_abort"},      bus.abort,      0);
      chk({tag, "_txUnderrun"}, bus.txUnderrun, 0);
   endtask

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (!resn) begin
         m_last_rx = '0;
         exp_rx.delete();
         ss_stable = 0;
         ss_prev   = bus.SS;
      end else begin
         if (bus.SS != ss_prev) ss_stable = 0;
         else if (ss_stable < 1000) ss_stable++;
         ss_prev = bus.SS;
         if (bus.rxValid) begin
            obs_rxv++;
            if (exp_rx.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL rxValid_unexpected: got rxData %h required no pulse (t=%0t)",
                        bus.rxData, $time);
            end else begin
               m_last_rx = exp_rx.pop_front();
               chk("rxData_on_valid", bus.rxData, m_last_rx);
            end
         end else begin
            chk("rxData_held", bus.rxData, m_last_rx);
         end
         if (bus.abort)      obs_abort++;
         if (bus.txUnderrun) obs_under++;
         chk("rxValid_abort_overlap", bus.rxValid & bus.abort, 0);
         if (ss_stable >= 5) begin
            chk("busy", bus.busy, !bus.SS);
            if (bus.SS) chk("MISO_idle", bus.MISO, 0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] m0, m1, e0, e1;
      bus.SCLK = 1'b0; bus.SS = 1'b1; bus.MOSI = 1'b0;
      bus.txData = '0; bus.txWrite = 1'b0;
      resn = 1'b0;
      #1;
      chk_reset_outputs("reset");
      tick(3);
      resn = 1'b1;
      tick(10);

      // Single word
      tx_write(16'hA55A);
      ss_fall(e0);
      spi_bits(16'h1234, 16, 1'b1, m0);
      chk("t1_miso_model", m0, e0);
      chk("t1_miso_lit", m0, 16'hA55A);
      chk("t1_rxData", bus.rxData, 16'h1234);
      chk("t1_txReady", bus.txReady, 1);
      chk_events("t1");

      // Back-to-back words with a mid-word refill
      tx_write(16'hC3C3);
      ss_fall(e0);
      fork
         spi_bits(16'hBEEF, 16, 1'b0, m0);
         begin
            tick(8*HALF);
            tx_write(16'h0F0F);
         end
      join
      model_slot(e1);
      spi_bits(16'h0001, 16, 1'b1, m1);
      chk("t2_miso0_model", m0, e0);
      chk("t2_miso0_lit", m0, 16'hC3C3);
      chk("t2_miso1_model", m1, e1);
      chk("t2_miso1_lit", m1, 16'h0F0F);
      chk("t2_rxData", bus.rxData, 16'h0001);
      chk_events("t2");

      // Empty buffer
      ss_fall(e0);
      spi_bits(16'h6DB6, 16, 1'b1, m0);
      chk("t3_miso_model", m0, e0);
      chk("t3_miso_lit", m0, 16'h0000);
      chk("t3_rxData", bus.rxData, 16'h6DB6);
      chk("t3_underrun_lit", obs_under, 1);
      chk_events("t3");

      // Abort after 7 bits, then a clean frame
      tx_write(16'h5AA5);
      ss_fall(e0);
      spi_bits(16'hFFFF, 7, 1'b1, m0);
      chk("t4_rxData_kept", bus.rxData, 16'h6DB6);
      chk("t4_MISO", bus.MISO, 0);
      chk("t4_abort_lit", obs_abort, 1);
      chk_events("t4a");
      tx_write(16'h7E81);
      ss_fall(e0);
      spi_bits(16'h8001, 16, 1'b1, m0);
      chk("t4_miso_model", m0, e0);
      chk("t4_miso_lit", m0, 16'h7E81);
      chk("t4_rxData", bus.rxData, 16'h8001);
      chk_events("t4b");

      // Write to a full buffer is ignored; bypass write at the slot load
      tx_write(16'h2222);
      tx_write(16'h1111);
      chk("t5_txReady_full", bus.txReady, 0);
      ss_fall(e0);
      spi_bits(16'h4321, 16, 1'b1, m0);
      chk("t5_miso_model", m0, e0);
      chk("t5_miso_lit", m0, 16'h2222);
      ss_fall_bypass(16'h3333, e0);
      chk("t5_bypass_txReady", bus.txReady, 1);
      spi_bits(16'hA0A0, 16, 1'b1, m0);
      chk("t5_bypass_model", m0, e0);
      chk("t5_bypass_lit", m0, 16'h3333);
      chk("t5_rxData", bus.rxData, 16'hA0A0);
      chk_events("t5");

      // Reset mid-frame after 9 bits
      tx_write(16'h9999);
      ss_fall(e0);
      spi_bits(16'hFFFF, 9, 1'b0, m0);
      #1;
      resn = 1'b0;
      #1;
      chk_reset_outputs("t6_reset");
      bus.SS     = 1'b1;
      m_buf_full = 1'b0;
      tick(10);
      resn = 1'b1;
      tick(10);
      tx_write(16'h1357);
      ss_fall(e0);
      spi_bits(16'h2468, 16, 1'b1, m0);
      chk("t6_miso_model", m0, e0);
      chk("t6_miso_lit", m0, 16'h1357);
      chk("t6_rxData", bus.rxData, 16'h2468);
      chk_events("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
